// File: rtl/spinn_link_2of7_tx.sv
// SpiNNaker link transmitter: serialises one parallel packet as NRZ 2-of-7
// symbols (LS nibble first, then EOP), one symbol per receiver ack toggle.
module spinn_link_2of7_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [71:0] pkt_data,
  input  logic        pkt_vld,
  output logic        pkt_rdy,
  output logic        pkt_sent,
  output logic [6:0]  data_2of7_to_spinnaker,
  input  logic        ack_from_spinnaker
);

  localparam logic [6:0] EOP_CODE = 7'b1100000;

  typedef enum logic [1:0] {IDLE, SEND, EOP} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    ack_s;
  logic                    ack_ref;
  logic                    ack_seen;
  logic [4:0]              cnt;
  logic [4:0]              last;
  // Only nibbles 1..17 need holding; nibble 0 is encoded straight from the input.
  logic [67:0]             nib;

  function automatic logic [6:0] code7(input logic [3:0] n);
    case (n)
      4'h0: code7 = 7'b0010001;
      4'h1: code7 = 7'b0010010;
      4'h2: code7 = 7'b0010100;
      4'h3: code7 = 7'b0011000;
      4'h4: code7 = 7'b0100001;
      4'h5: code7 = 7'b0100010;
      4'h6: code7 = 7'b0100100;
      4'h7: code7 = 7'b0101000;
      4'h8: code7 = 7'b1000001;
      4'h9: code7 = 7'b1000010;
      4'hA: code7 = 7'b1000100;
      4'hB: code7 = 7'b1001000;
      4'hC: code7 = 7'b0000011;
      4'hD: code7 = 7'b0000110;
      4'hE: code7 = 7'b0001100;
      default: code7 = 7'b0001001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], ack_from_spinnaker};
  end

  assign ack_s    = sync[SYNC_STAGES-1];
  assign ack_seen = (ack_s != ack_ref);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      data_2of7_to_spinnaker <= 7'b0;
      pkt_rdy                <= 1'b0;
      pkt_sent               <= 1'b0;
      ack_ref                <= 1'b0;
      cnt                    <= 5'd0;
      last                   <= 5'd0;
      nib                    <= '0;
    end else begin
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          // Absorb any receiver toggles while no symbol is outstanding.
          ack_ref <= ack_s;
          pkt_rdy <= 1'b1;
          if (pkt_vld && pkt_rdy) begin
            nib                    <= pkt_data[71:4];
            last                   <= pkt_data[1] ? 5'd17 : 5'd9;
            cnt                    <= 5'd0;
            data_2of7_to_spinnaker <= data_2of7_to_spinnaker ^ code7(pkt_data[3:0]);
            pkt_rdy                <= 1'b0;
            state                  <= SEND;
          end
        end
        SEND: begin
          if (ack_seen) begin
            ack_ref <= ~ack_ref;
            if (cnt == last) begin
              data_2of7_to_spinnaker <= data_2of7_to_spinnaker ^ EOP_CODE;
              state                  <= EOP;
            end else begin
              nib                    <= {4'b0, nib[67:4]};
              cnt                    <= cnt + 5'd1;
              data_2of7_to_spinnaker <= data_2of7_to_spinnaker ^ code7(nib[3:0]);
            end
          end
        end
        EOP: begin
          if (ack_seen) begin
            ack_ref  <= ~ack_ref;
            pkt_sent <= 1'b1;
            pkt_rdy  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spinn_link_2of7_tx.sv
// Bench for spinn_link_2of7_tx: acts as the link receiver and checks every
// symbol against the expected NRZ 2-of-7 stream derived from the packet.
module tb_spinn_link_2of7_tx;
  localparam int SYNC = 2;
  localparam logic [6:0] EOP_C = 7'b1100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] pkt_data;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic        pkt_sent;
  logic [6:0]  data;
  logic        ack;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [6:0]  lnk;
  bit          keep_vld;
  logic [6:0]  code_tab [16];

  spinn_link_2of7_tx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld),
    .pkt_rdy(pkt_rdy), .pkt_sent(pkt_sent),
    .data_2of7_to_spinnaker(data), .ack_from_spinnaker(ack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [71:0] p);
    pkt_data = p;
    pkt_vld  = 1'b1;
  endtask

  // Receive one packet: expect each symbol, ack it after dly cycles.
  task automatic rx(input logic [71:0] pkt, input int dly, input bit stall,
                    input int abort, input bit has_nxt, input logic [71:0] nxt);
    int n;
    int k;
    int moved;
    logic [6:0] expd;
    n = pkt[1] ? 18 : 10;
    for (int i = 0; i <= n; i++) begin
      expd = lnk ^ ((i < n) ? code_tab[pkt[4*i +: 4]] : EOP_C);
      k = 0;
      while (data === lnk && k < 200) begin @(negedge clk); k++; end
      if (data === lnk) begin
        chk("sym_timeout", {65'b0, data}, {65'b0, expd});
        return;
      end
      chk("sym", {65'b0, data}, {65'b0, expd});
      chk("rdy_low", {71'b0, pkt_rdy}, 72'd0);
      if (i == 0 && !keep_vld) pkt_vld = 1'b0;
      lnk = data;
      if (stall && i == 0) begin
        moved = 0;
        repeat (1000) begin
          @(negedge clk);
          if (data !== lnk) moved++;
        end
        chk("stall_hold", moved, 0);
      end
      repeat (dly) @(negedge clk);
      if (i == n && has_nxt) pkt_data = nxt;
      ack = ~ack;
      if (stall && i == 0) begin
        repeat (SYNC) @(negedge clk);
        chk("stall_early", {65'b0, data}, {65'b0, lnk});
        @(negedge clk);
        chk("stall_resume", {65'b0, data}, {65'b0, lnk ^ code_tab[pkt[7:4]]});
      end
      if (abort == i + 1) begin
        moved = 0;
        repeat (SYNC + 2) begin
          @(negedge clk);
          if (pkt_sent) moved++;
        end
        rst = 1'b1;
        repeat (2) begin
          @(negedge clk);
          if (pkt_sent) moved++;
        end
        chk("abort_data", {65'b0, data}, 72'd0);
        chk("abort_rdy", {71'b0, pkt_rdy}, 72'd0);
        rst = 1'b0;
        @(negedge clk);
        if (pkt_sent) moved++;
        chk("abort_rdy_up", {71'b0, pkt_rdy}, 72'd1);
        chk("abort_no_sent", moved, 0);
        lnk = 7'b0;
        return;
      end
    end
    k = 0;
    while (!pkt_sent && k < 50) begin @(negedge clk); k++; end
    chk("sent_pulse", {71'b0, pkt_sent}, 72'd1);
    chk("rdy_at_sent", {71'b0, pkt_rdy}, 72'd1);
    @(negedge clk);
    chk("sent_once", {71'b0, pkt_sent}, 72'd0);
    if (has_nxt) chk("b2b_first", {65'b0, data}, {65'b0, lnk ^ code_tab[nxt[3:0]]});
    else         chk("idle_hold", {65'b0, data}, {65'b0, lnk});
  endtask

  initial begin
    logic [71:0] p;
    logic [71:0] q;
    logic [31:0] base;
    code_tab = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                 7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                 7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                 7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001};
    rst = 1'b1; pkt_vld = 1'b0; pkt_data = '0; ack = 1'b0;
    lnk = 7'b0; keep_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", {65'b0, data}, 72'd0);
    chk("rst_rdy", {71'b0, pkt_rdy}, 72'd0);
    chk("rst_sent", {71'b0, pkt_sent}, 72'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {71'b0, pkt_rdy}, 72'd1);

    // Short all-zero packet: ten identical symbols cancel, leaving only EOP.
    present(72'h0);
    rx(72'h0, 8, 1'b0, 0, 1'b0, 72'h0);
    chk("short_final", {65'b0, data}, {65'b0, EOP_C});

    p = {64'h0123_4567_89AB_CDEF, 8'h02};
    present(p);
    rx(p, 3, 1'b0, 0, 1'b0, 72'h0);

    p = {32'h0, $urandom, 8'h0} | 72'($urandom_range(0, 255) & 8'hFD);
    present(p);
    rx(p, 2, 1'b1, 0, 1'b0, 72'h0);

    // Receiver toggles while idle must not produce symbols.
    repeat (3) begin
      repeat (5) @(negedge clk);
      ack = ~ack;
    end
    repeat (8) @(negedge clk);
    chk("spur_data", {65'b0, data}, {65'b0, lnk});
    chk("spur_rdy", {71'b0, pkt_rdy}, 72'd1);
    p = {32'h0, $urandom, 8'h0} | 72'($urandom_range(0, 255) & 8'hFD);
    present(p);
    rx(p, 0, 1'b0, 0, 1'b0, 72'h0);

    p = {32'h0, $urandom, 8'h0} | 72'($urandom_range(0, 255) & 8'hFD);
    present(p);
    rx(p, 4, 1'b0, 4, 1'b0, 72'h0);
    present(72'h0);
    rx(72'h0, 1, 1'b0, 0, 1'b0, 72'h0);

    keep_vld = 1'b1;
    base = $urandom;
    p = {32'h0, base, 8'h0};
    present(p);
    for (int k = 0; k < 4; k++) begin
      q = {32'h0, base + 32'(k + 1), 8'h0};
      if (k == 3) keep_vld = 1'b0;
      rx(p, 1, 1'b0, 0, k < 3, q);
      p = q;
    end

    repeat (4) begin
      p = {$urandom, $urandom, 8'($urandom)};
      present(p);
      rx(p, $urandom_range(0, 6), 1'b0, 0, 1'b0, 72'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
